// File: rtl/nkmd_uart_txfifo_if.sv
// rtl/nkmd_uart_txfifo_if.sv - CPU-side and core-side signals of the UART TX FIFO
interface nkmd_uart_txfifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          wr_data_i;
  logic                wr_en_i;
  logic                flush_i;
  logic                clr_ovf_i;
  logic [7:0]          core_data_o;
  logic                core_ack_o;
  logic                core_pop_i;
  logic [DEPTH_LOG2:0] count_o;
  logic                empty_o;
  logic                full_o;
  logic                ovf_o;

  // Bus decode / uart core side driving the FIFO
  modport master (
    output wr_data_i, wr_en_i, flush_i, clr_ovf_i, core_pop_i,
    input  core_data_o, core_ack_o, count_o, empty_o, full_o, ovf_o
  );

  // The FIFO itself
  modport slave (
    input  wr_data_i, wr_en_i, flush_i, clr_ovf_i, core_pop_i,
    output core_data_o, core_ack_o, count_o, empty_o, full_o, ovf_o
  );
endinterface

// File: rtl/nkmd_uart_txfifo.sv
// rtl/nkmd_uart_txfifo.sv - transmit byte FIFO between CPU bus writes and the uart core
module nkmd_uart_txfifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  nkmd_uart_txfifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  core_rdy;
  logic                  ovf;
  logic [7:0]            core_data;
  logic                  core_ack;

  logic empty;
  logic full;
  logic launch;
  logic wr_accept;
  logic ovf_set;

  // Count only ever reaches DEPTH, so its top bit alone marks full.
  assign empty     = (count == '0);
  assign full      = count[DEPTH_LOG2];
  // A byte goes to the core only when it has signalled ready; flush suppresses it.
  assign launch    = !empty && core_rdy && !bus.flush_i;
  // A launch frees a slot in the same cycle, so a full FIFO can still take a write then.
  assign wr_accept = bus.wr_en_i && !bus.flush_i && (!full || launch);
  assign ovf_set   = bus.wr_en_i && full && !launch && !bus.flush_i;

  assign bus.core_data_o = core_data;
  assign bus.core_ack_o  = core_ack;
  assign bus.count_o     = count;
  assign bus.empty_o     = empty;
  assign bus.full_o      = full;
  assign bus.ovf_o       = ovf;

  // Storage array write port; contents are don't-care until pointers cover them.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= bus.wr_data_i;
    end
  end

  // Pointers, occupancy, core handshake and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      core_rdy  <= 1'b1;
      ovf       <= 1'b0;
      core_data <= 8'h00;
      core_ack  <= 1'b0;
    end else begin
      core_ack <= launch;

      if (launch) begin
        core_data <= mem[rd_ptr];
      end

      // Launch clearing ready takes priority over a coincident pop.
      if (launch) begin
        core_rdy <= 1'b0;
      end else if (bus.core_pop_i) begin
        core_rdy <= 1'b1;
      end

      if (bus.flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_accept) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (launch) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        case ({wr_accept, launch})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end

      // A new overflow event outranks a simultaneous clear.
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (bus.clr_ovf_i) begin
        ovf <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nkmd_uart_txfifo.sv
// tb/tb_nkmd_uart_txfifo.sv - directed self-checking bench for nkmd_uart_txfifo
module tb_nkmd_uart_txfifo;
  logic clk;
  logic rst;

  nkmd_uart_txfifo_if #(.DEPTH_LOG2(4)) bus ();

  nkmd_uart_txfifo #(.DEPTH_LOG2(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       flush;
    logic       clr;
    logic       pop;
    logic [4:0] cnt;
    logic       ack;
    logic [7:0] dout;
    logic       ovf;
    logic       full;
    logic       empty;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wr, input logic [7:0] data, input logic flush,
                       input logic clr, input logic pop);
    bus.wr_en_i   = wr;
    bus.wr_data_i = data;
    bus.flush_i   = flush;
    bus.clr_ovf_i = clr;
    bus.core_pop_i = pop;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] data, input logic pop,
                              input logic [4:0] cnt, input logic ack, input logic [7:0] dout);
    vec_t v;
    v.wr = wr; v.data = data; v.flush = 1'b0; v.clr = 1'b0; v.pop = pop;
    v.cnt = cnt; v.ack = ack; v.dout = dout; v.ovf = 1'b0;
    v.full = (cnt == 5'd16); v.empty = (cnt == 5'd0);
    return v;
  endfunction

  vec_t tbl [20];
  logic [7:0] exp_seq [16];
  int acks;

  initial begin
    rst = 1'b0;
    idle();
    repeat (3) tick();
    chk("reset_count", bus.count_o, 0);
    chk("reset_empty", bus.empty_o, 1);
    chk("reset_full", bus.full_o, 0);
    chk("reset_ovf", bus.ovf_o, 0);
    chk("reset_ack", bus.core_ack_o, 0);
    chk("reset_data", bus.core_data_o, 8'h00);
    rst = 1'b1;

    // single byte latency, redundant pop, pop coinciding with launch
    tbl[0]  = mk(1, 8'h41, 0, 1, 0, 8'h00);
    tbl[1]  = mk(0, 8'h00, 0, 0, 1, 8'h41);
    tbl[2]  = mk(0, 8'h00, 0, 0, 0, 8'h41);
    tbl[3]  = mk(0, 8'h00, 1, 0, 0, 8'h41);
    tbl[4]  = mk(0, 8'h00, 1, 0, 0, 8'h41);
    tbl[5]  = mk(1, 8'h61, 0, 1, 0, 8'h41);
    tbl[6]  = mk(1, 8'h62, 0, 1, 1, 8'h61);
    tbl[7]  = mk(0, 8'h00, 0, 1, 0, 8'h61);
    tbl[8]  = mk(0, 8'h00, 0, 1, 0, 8'h61);
    tbl[9]  = mk(0, 8'h00, 1, 1, 0, 8'h61);
    tbl[10] = mk(0, 8'h00, 0, 0, 1, 8'h62);
    tbl[11] = mk(0, 8'h00, 1, 0, 0, 8'h62);
    tbl[12] = mk(1, 8'h71, 0, 1, 0, 8'h62);
    tbl[13] = mk(0, 8'h00, 1, 0, 1, 8'h71);
    tbl[14] = mk(0, 8'h00, 0, 0, 0, 8'h71);
    tbl[15] = mk(1, 8'h72, 0, 1, 0, 8'h71);
    tbl[16] = mk(0, 8'h00, 0, 1, 0, 8'h71);
    tbl[17] = mk(0, 8'h00, 1, 1, 0, 8'h71);
    tbl[18] = mk(0, 8'h00, 0, 0, 1, 8'h72);
    tbl[19] = mk(0, 8'h00, 1, 0, 0, 8'h72);
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].wr, tbl[i].data, tbl[i].flush, tbl[i].clr, tbl[i].pop);
      tick();
      chk($sformatf("v%0d_count", i), bus.count_o, tbl[i].cnt);
      chk($sformatf("v%0d_ack", i), bus.core_ack_o, tbl[i].ack);
      chk($sformatf("v%0d_data", i), bus.core_data_o, tbl[i].dout);
      chk($sformatf("v%0d_ovf", i), bus.ovf_o, tbl[i].ovf);
      chk($sformatf("v%0d_full", i), bus.full_o, tbl[i].full);
      chk($sformatf("v%0d_empty", i), bus.empty_o, tbl[i].empty);
    end

    // burst fill, overflow, write-in-launch-cycle on full, ordered drain across wrap
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      tick();
      if (i == 2) begin
        chk("burst_first_ack", bus.core_ack_o, 1);
        chk("burst_first_data", bus.core_data_o, 8'h01);
      end
    end
    chk("burst_count15", bus.count_o, 15);
    chk("burst_full0", bus.full_o, 0);
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    tick();
    chk("burst_count16", bus.count_o, 16);
    chk("burst_full1", bus.full_o, 1);
    chk("burst_ovf0", bus.ovf_o, 0);
    drive(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ovf_set", bus.ovf_o, 1);
    chk("ovf_count", bus.count_o, 16);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    chk("ovf_clear", bus.ovf_o, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    chk("pop_no_ack", bus.core_ack_o, 0);
    drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    tick();
    chk("full_launch_ack", bus.core_ack_o, 1);
    chk("full_launch_data", bus.core_data_o, 8'h02);
    chk("full_launch_count", bus.count_o, 16);
    chk("full_launch_ovf", bus.ovf_o, 0);
    for (int k = 0; k < 15; k++) exp_seq[k] = 8'(k + 3);
    exp_seq[15] = 8'hAA;
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      idle();
      tick();
      chk($sformatf("drain%0d_ack", k), bus.core_ack_o, 1);
      chk($sformatf("drain%0d_data", k), bus.core_data_o, exp_seq[k]);
      acks = 0;
      repeat (8) begin
        tick();
        if (bus.core_ack_o) acks++;
      end
      chk($sformatf("drain%0d_gap", k), acks, 0);
    end
    chk("drain_count", bus.count_o, 0);
    chk("drain_empty", bus.empty_o, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    acks = 0;
    repeat (5) begin
      tick();
      if (bus.core_ack_o) acks++;
    end
    chk("no_extra_byte", acks, 0);

    // flush with core busy, then flush with core ready
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'(8'h21 + i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("preflush_count", bus.count_o, 5);
    drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    tick();
    chk("flush_count", bus.count_o, 0);
    chk("flush_ovf", bus.ovf_o, 0);
    chk("flush_ack", bus.core_ack_o, 0);
    chk("flush_data", bus.core_data_o, 8'h21);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    acks = 0;
    repeat (5) begin
      tick();
      if (bus.core_ack_o) acks++;
    end
    chk("flush_no55", acks, 0);
    drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rdyflush_pre", bus.count_o, 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rdyflush_ack", bus.core_ack_o, 0);
    chk("rdyflush_count", bus.count_o, 0);
    idle();
    acks = 0;
    repeat (3) begin
      tick();
      if (bus.core_ack_o) acks++;
    end
    chk("rdyflush_quiet", acks, 0);
    drive(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("rdy_kept_ack", bus.core_ack_o, 1);
    chk("rdy_kept_data", bus.core_data_o, 8'h34);

    // overflow set beats simultaneous clear
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("refill_full", bus.full_o, 1);
    drive(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    tick();
    chk("set_beats_clr", bus.ovf_o, 1);
    chk("set_beats_clr_cnt", bus.count_o, 16);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    chk("clr_alone", bus.ovf_o, 0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    idle();

    // asynchronous reset in the middle of a transfer
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'hC1 + i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("prerst_count", bus.count_o, 3);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    chk("prerst_ack", bus.core_ack_o, 1);
    chk("prerst_data", bus.core_data_o, 8'hC1);
    #2 rst = 1'b0;
    #1;
    chk("rst_count", bus.count_o, 0);
    chk("rst_ack", bus.core_ack_o, 0);
    chk("rst_empty", bus.empty_o, 1);
    chk("rst_data", bus.core_data_o, 8'h00);
    tick();
    rst = 1'b1;
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    tick();
    chk("postrst_count", bus.count_o, 1);
    idle();
    tick();
    chk("postrst_ack", bus.core_ack_o, 1);
    chk("postrst_data", bus.core_data_o, 8'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
